sqr_iter: RTL and testbench

- Iterative integer squarer. It is the inverse companion of the iterative square-root block: an N-bit root goes in, a 2N-bit square comes out.
- The default algorithm accumulates consecutive odd numbers (1+3+5+...), mirroring the odd-increment search used by the square-root datapath.
- Used to generate and self-check sqrt stimulus (sqrt(square(x)) == x) and as a standalone arithmetic unit.
- FSM controller plus accumulator datapath in one module; start/busy/done handshake with a functional clock enable (no gated clock).

---
 rtl/sqr_iter.sv | 142 ++++++++++++++
 tb/tb_sqr_iter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sqr_iter.sv
// sqr_iter: iterative integer squarer, WIDTH-bit root in, 2*WIDTH-bit square out.
// Default build sums consecutive odd numbers (1+3+5+...), taking n+1 cycles.
// Define SQR_ITER_FAST_EN to use a shift-add multiplier instead (WIDTH+1 cycles).
// A zero operand always takes the one-cycle shortcut straight to DONE.
module sqr_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enb_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     dt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   dt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   addend;
  logic                 lastStep;

`ifdef SQR_ITER_FAST_EN
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(WIDTH - 1);

  logic [WIDTH-1:0]     nShifted;

  // Shift-add step: add n shifted by the current bit position when that bit of n is set
  always_comb begin
    nShifted = n_q >> cnt_q;
    addend   = '0;
    if (nShifted[0]) begin
      addend = {{WIDTH{1'b0}}, n_q} << cnt_q;
    end
    lastStep = (cnt_q == LAST_CNT);
  end
`else
  logic [WIDTH:0]       odd_q, odd_d;

  // Odd-accumulation step: the next odd number is added each cycle, n adds in total
  always_comb begin
    addend   = {{(WIDTH-1){1'b0}}, odd_q};
    lastStep = (cnt_q == n_q - ONE);
  end
`endif

  // Next-state and datapath updates; everything holds unless the clock enable is high
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
`ifndef SQR_ITER_FAST_EN
    odd_d   = odd_q;
`endif
    if (enb_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_d   = dt_i;
            cnt_d = '0;
            acc_d = '0;
`ifndef SQR_ITER_FAST_EN
            odd_d = (WIDTH+1)'(1);
`endif
            if (dt_i == '0) begin
              res_d   = '0;
              state_d = DONE;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          acc_d = acc_q + addend;
          cnt_d = cnt_q + ONE;
`ifndef SQR_ITER_FAST_EN
          odd_d = odd_q + (WIDTH+1)'(2);
`endif
          if (lastStep) begin
            res_d   = acc_q + addend;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset that overrides the enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef SQR_ITER_FAST_EN
      odd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifndef SQR_ITER_FAST_EN
      odd_q   <= odd_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dt_o   = res_q;

endmodule

// File: tb/tb_sqr_iter.sv
// tb_sqr_iter: directed self-checking bench for sqr_iter (either build of the datapath).
module tb_sqr_iter;

  localparam int WIDTH  = 8;
  localparam int BUDGET = 400;
`ifdef SQR_ITER_FAST_EN
  localparam int RST_AT = 5;
`else
  localparam int RST_AT = 50;
`endif

  logic                clk;
  logic                rst;
  logic                enb;
  logic                start;
  logic [WIDTH-1:0]    dt;
  logic                busy;
  logic                done;
  logic [2*WIDTH-1:0]  result;

  int assertCount = 0;
  int failCount   = 0;

  sqr_iter #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .enb_i   (enb),
    .start_i (start),
    .dt_i    (dt),
    .busy_o  (busy),
    .done_o  (done),
    .dt_o    (result)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from the accepting edge (counted as cycle 1) until done_o is seen
  function automatic int expLat(input int n);
    if (n == 0) return 1;
`ifdef SQR_ITER_FAST_EN
    return WIDTH + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic s, input logic [WIDTH-1:0] d);
    rst   = r;
    enb   = e;
    start = s;
    dt    = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic runUntilDone(output int cycles, output int busyCount);
    cycles    = 0;
    busyCount = 0;
    while (cycles < BUDGET) begin
      stepCycle();
      cycles++;
      if (busy) busyCount++;
      if (done) break;
    end
    if (!done) cycles = -1;
  endtask

  initial begin
    int  c;
    int  bc;
    logic [2*WIDTH-1:0] held;
    logic sawDone;

    // Reset with the enable low: reset must still take effect
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    stepCycle();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);

    // Zero operand: done right after the accepting edge
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd1);
    checkOutput("zero_result", 32'(result), 32'd0);
    stepCycle();
    checkOutput("zero_done_pulse", 32'(done), 32'd0);

    // n = 13
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd13);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    runUntilDone(c, bc);
    checkOutput("n13_latency", 32'(1 + c), 32'(expLat(13)));
    checkOutput("n13_busy_cycles", 32'(1 + bc), 32'(expLat(13)));
    checkOutput("n13_result", 32'(result), 32'd169);
    stepCycle();
    checkOutput("n13_done_pulse", 32'(done), 32'd0);
    checkOutput("n13_result_hold", 32'(result), 32'd169);

    // n = 255 with a three-cycle enable gap while busy
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd255);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("freeze_busy", 32'(busy), 32'd1);
    checkOutput("freeze_done", 32'(done), 32'd0);
    checkOutput("freeze_result", 32'(result), 32'd169);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    runUntilDone(c, bc);
    checkOutput("n255_latency", 32'(7 + c), 32'(expLat(255) + 3));
    checkOutput("n255_result", 32'(result), 32'd65025);
    // Done pulse stretches while the enable is low
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    stepCycle();
    stepCycle();
    checkOutput("stretch_done", 32'(done), 32'd1);
    checkOutput("stretch_result", 32'(result), 32'd65025);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    stepCycle();
    checkOutput("stretch_end_done", 32'(done), 32'd0);
    checkOutput("stretch_end_busy", 32'(busy), 32'd0);

    // n = 7 with start held high and the operand changed after acceptance
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd200);
    runUntilDone(c, bc);
    checkOutput("n7_latency", 32'(1 + c), 32'(expLat(7)));
    checkOutput("n7_result", 32'(result), 32'd49);
    stepCycle();
    checkOutput("n7_idle_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("n200_accepted", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("n200_result_hold", 32'(result), 32'd49);
    runUntilDone(c, bc);
    checkOutput("n200_latency", 32'(1 + c), 32'(expLat(200)));
    checkOutput("n200_result", 32'(result), 32'd40000);
    stepCycle();

    // n = 100 aborted by reset mid-computation
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd100);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    sawDone = 1'b0;
    for (int i = 1; i < RST_AT; i++) begin
      stepCycle();
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    stepCycle();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    held = result;
    checkOutput("abort_result_idle", 32'(held), 32'd0);

    // n = 3 after the abort
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd3);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    runUntilDone(c, bc);
    checkOutput("n3_latency", 32'(1 + c), 32'(expLat(3)));
    checkOutput("n3_result", 32'(result), 32'd9);
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
